// File: rtl/mod_counter_pkg.sv
// Shared types and constants for the modulo counter.
package mod_counter_pkg;

  // Behaviour at the count boundary: wrap around or saturate.
  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/mod_counter_prescaler.sv
// Step prescaler: emits one tick every PRESCALE enabled cycles.
module mod_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick
);

  if (PRESCALE == 1) begin : g_bypass
    // No phase to track; every enabled cycle is a step.
    logic unused_ports;
    assign unused_ports = ^{clk, reset, restart};
    assign tick = en;
  end else begin : g_div
    localparam int unsigned PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    // Phase advances on enabled cycles, returns to zero after the last one.
    always_comb begin
      phase_d = phase_q;
      if (restart) begin
        phase_d = '0;
      end else if (en) begin
        phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
      end
    end

    // Phase register.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        phase_q <= '0;
      end else begin
        phase_q <= phase_d;
      end
    end

    assign tick = en & (phase_q == LAST);
  end

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with prescaler, terminal-count pulse and sticky boundary flag.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned MODULUS  = 2 ** WIDTH,
  parameter int unsigned PRESCALE = 1,
  parameter cnt_mode_e   MODE     = CNT_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             tick;
  logic             at_bound;
  logic [WIDTH-1:0] load_clamped;

  mod_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .restart (clr | load),
    .tick    (tick)
  );

  // Out-of-range load values are only possible when MODULUS leaves codes unused.
  if (MODULUS < (2 ** WIDTH)) begin : g_clamp
    assign load_clamped = (load_val > MAX_Q) ? MAX_Q : load_val;
  end else begin : g_noclamp
    assign load_clamped = load_val;
  end

  // Next count, terminal-count pulse and sticky flag; clr beats load beats step.
  always_comb begin
    count_d  = count_q;
    tc_d     = 1'b0;
    ovf_d    = ovf_q & ~ovf_clr;
    at_bound = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_clamped;
    end else if (tick) begin
      if (up_dn) begin
        if (count_q == MAX_Q) begin
          at_bound = 1'b1;
          if (MODE == CNT_WRAP) count_d = '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          at_bound = 1'b1;
          if (MODE == CNT_WRAP) count_d = MAX_Q;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
    if (at_bound) begin
      tc_d  = 1'b1;
      ovf_d = 1'b1;
    end
  end

  // Count and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q   = count_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: three configurations driven in parallel against a behavioural model.
module tb_mod_counter;
  import mod_counter_pkg::*;

  localparam int NDUT = 3;
  localparam int MODV [NDUT] = '{10, 10, 10};
  localparam int PSV  [NDUT] = '{1, 1, 3};
  localparam bit SATV [NDUT] = '{1'b0, 1'b1, 1'b0};

  typedef struct {
    int q;
    int ph;
    bit tc;
    bit ovf;
  } mstate_t;

  logic       clk;
  logic       reset;
  logic       en, up_dn, clr, load, ovf_clr;
  logic [3:0] load_val;
  logic [3:0] dq   [NDUT];
  logic       dtc  [NDUT];
  logic       dovf [NDUT];

  mstate_t ms [NDUT];
  int n_chk = 0;
  int n_err = 0;

  mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .MODE(CNT_WRAP)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .ovf_clr(ovf_clr), .q(dq[0]), .tc(dtc[0]), .ovf(dovf[0]));

  mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .MODE(CNT_SAT)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .ovf_clr(ovf_clr), .q(dq[1]), .tc(dtc[1]), .ovf(dovf[1]));

  mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .MODE(CNT_WRAP)) u_ps3 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .ovf_clr(ovf_clr), .q(dq[2]), .tc(dtc[2]), .ovf(dovf[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One cycle of the reference behaviour for a counter of modulus m, prescale p.
  function automatic mstate_t mstep(mstate_t s, int m, int p, bit sat);
    mstate_t r;
    bit      bnd;
    r     = s;
    r.tc  = 1'b0;
    if (ovf_clr) r.ovf = 1'b0;
    if (clr) begin
      r.q  = 0;
      r.ph = 0;
    end else if (load) begin
      r.q  = (int'(load_val) >= m) ? m - 1 : int'(load_val);
      r.ph = 0;
    end else if (en) begin
      if (s.ph == p - 1) begin
        r.ph = 0;
        bnd  = up_dn ? (s.q == m - 1) : (s.q == 0);
        if (!(bnd && sat)) r.q = (s.q + (up_dn ? 1 : m - 1)) % m;
        if (bnd) begin
          r.tc  = 1'b1;
          r.ovf = 1'b1;
        end
      end else begin
        r.ph = s.ph + 1;
      end
    end
    return r;
  endfunction

  // Reference model state, reset asynchronously like the design.
  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < NDUT; i++) begin
      if (!reset) ms[i] = '{0, 0, 1'b0, 1'b0};
      else        ms[i] = mstep(ms[i], MODV[i], PSV[i], SATV[i]);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, each DUT is compared against its model.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("model_q[%0d]", i),   int'(dq[i]),   ms[i].q);
      chk($sformatf("model_tc[%0d]", i),  int'(dtc[i]),  int'(ms[i].tc));
      chk($sformatf("model_ovf[%0d]", i), int'(dovf[i]), int'(ms[i].ovf));
    end
  end

  task automatic cyc(input bit e, input bit u, input bit c, input bit l,
                     input int lv, input bit oc);
    @(negedge clk);
    en = e; up_dn = u; clr = c; load = l; load_val = 4'(lv); ovf_clr = oc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0; ovf_clr = 1'b0;
    #2;
    chk("reset_q", int'(dq[0]), 0);
    chk("reset_ovf", int'(dovf[0]), 0);
    @(negedge clk);
    reset = 1'b1;

    // Count up from reset.
    for (int k = 0; k < 9; k++) cyc(1, 1, 0, 0, 0, 0);
    chk("up9_wrap_q", int'(dq[0]), 9);
    chk("up9_wrap_tc", int'(dtc[0]), 0);
    chk("up9_ps3_q", int'(dq[2]), 3);
    cyc(1, 1, 0, 0, 0, 0);
    chk("wrap_to0_q", int'(dq[0]), 0);
    chk("wrap_to0_tc", int'(dtc[0]), 1);
    chk("wrap_to0_ovf", int'(dovf[0]), 1);
    chk("sat_hold_q", int'(dq[1]), 9);
    chk("sat_hold_tc", int'(dtc[1]), 1);
    cyc(1, 1, 0, 0, 0, 0);
    chk("wrap_q1", int'(dq[0]), 1);
    chk("wrap_tc_pulse", int'(dtc[0]), 0);

    // Down wrap from zero, then clamped load.
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("down_wrap_q", int'(dq[0]), 9);
    chk("down_wrap_tc", int'(dtc[0]), 1);
    cyc(1, 0, 0, 1, 13, 0);
    chk("load_clamp_q", int'(dq[0]), 9);
    chk("load_clamp_tc", int'(dtc[0]), 0);

    // Saturation held at the top, then down.
    cyc(0, 1, 0, 1, 8, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("sat_step9_tc", int'(dtc[1]), 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("sat_held1_tc", int'(dtc[1]), 1);
    cyc(1, 1, 0, 0, 0, 0);
    chk("sat_held2_q", int'(dq[1]), 9);
    chk("sat_held2_tc", int'(dtc[1]), 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("sat_down_q", int'(dq[1]), 8);

    // Prescale 3 with gaps in enable, and clr mid-phase.
    cyc(0, 1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("ps3_gap_q", int'(dq[2]), 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("ps3_step_q", int'(dq[2]), 1);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("ps3_restart_q", int'(dq[2]), 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("ps3_after_restart_q", int'(dq[2]), 1);

    // clr beats load; set beats clear on ovf.
    cyc(1, 1, 1, 1, 7, 0);
    chk("clr_over_load_q", int'(dq[0]), 0);
    cyc(0, 1, 0, 1, 9, 1);
    chk("ovf_cleared", int'(dovf[0]), 0);
    cyc(1, 1, 0, 0, 0, 1);
    chk("ovf_set_wins", int'(dovf[0]), 1);
    chk("ovf_set_wins_q", int'(dq[0]), 0);

    // Asynchronous reset mid-count.
    cyc(0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 1, 0, 0, 0, 0);
    chk("pre_reset_q", int'(dq[0]), 5);
    #2 reset = 1'b0;
    #1;
    chk("async_q", int'(dq[0]), 0);
    chk("async_ovf", int'(dovf[0]), 0);
    chk("async_ps3_q", int'(dq[2]), 0);
    en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cyc(1, 1, 0, 0, 0, 0);
    chk("resume_q1", int'(dq[0]), 1);
    cyc(1, 1, 0, 0, 0, 0);
    chk("resume_q2", int'(dq[0]), 2);

    // Random traffic with direction runs so both boundaries are reached.
    for (int k = 0; k < 3000; k++) begin
      bit u;
      u = up_dn;
      if ($urandom_range(0, 9) == 0) u = ~u;
      cyc($urandom_range(0, 9) < 7, u, $urandom_range(0, 63) == 0,
          $urandom_range(0, 11) == 0, int'($urandom_range(0, 15)),
          $urandom_range(0, 19) == 0);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, >= 1.
REQ-002 Parameter MODULUS, default 2**WIDTH: count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH.
REQ-003 Parameter PRESCALE, default 1: enabled cycles per count step, >= 1.
REQ-004 Parameter MODE, default CNT_WRAP: CNT_WRAP or CNT_SAT (package enum).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 en  in  1  count enable; prescaler advances only while high.
REQ-008 up_dn  in  1  direction: 1 = up, 0 = down.
REQ-009 clr  in  1  synchronous clear of count and prescaler.
REQ-010 load  in  1  synchronous load of load_val.
REQ-011 load_val  in  WIDTH  value for load.
REQ-012 ovf_clr  in  1  clears sticky ovf.
REQ-013 q  out  WIDTH  current count, registered.
REQ-014 tc  out  1  terminal-count pulse, registered.
REQ-015 ovf  out  1  sticky boundary flag, registered.

Function
REQ-016 Per-cycle priority: clr > load > step; lower-priority actions are ignored in that cycle.
REQ-017 clr: next q = 0, prescaler = 0, tc = 0; ovf unchanged.
REQ-018 load: next q = load_val, clamped to MODULUS-1 if load_val >= MODULUS; prescaler = 0; tc = 0.
REQ-019 Prescaler counts 0..PRESCALE-1 on en cycles; step occurs in the en cycle where it equals PRESCALE-1, then it returns to 0; PRESCALE=1 steps on every en cycle.
REQ-020 en low: q and prescaler hold; tc = 0.
REQ-021 Up step: q+1 if q < MODULUS-1; at MODULUS-1 -> 0 (CNT_WRAP) or hold (CNT_SAT).
REQ-022 Down step: q-1 if q > 0; at 0 -> MODULUS-1 (CNT_WRAP) or hold (CNT_SAT).
REQ-023 Boundary event = step taken while q is at the boundary for the current direction (MODULUS-1 up, 0 down), in either mode.
REQ-024 tc high exactly one cycle, in the cycle after a boundary event, aligned with the resulting q; CNT_SAT re-asserts tc on every further step held at the boundary.
REQ-025 ovf set by a boundary event; cleared by ovf_clr; simultaneous set and clear: set wins.
REQ-026 up_dn change takes effect on the next step; the prescaler phase is not disturbed.
REQ-027 No arithmetic result exceeds MODULUS-1; internal compares are WIDTH bits wide, no truncation.

Reset
REQ-028 reset low asynchronously forces q = 0, prescaler = 0, tc = 0, ovf = 0.
REQ-029 reset low mid-operation aborts any pending step; counting resumes from 0 with prescaler phase 0 on the first rising edge after deassertion.

Structure
REQ-030 Shared package holds mode enum (CNT_WRAP, CNT_SAT) and the default width constant.
REQ-031 One sub-module, mod_prescaler: parameter PRESCALE; inputs clk, reset, en, restart; output step tick; restart driven by clr|load.
REQ-032 PRESCALE=1 elaborates to no prescaler register (tick = en).

Verification (WIDTH=4, MODULUS=10, PRESCALE=1 unless stated)
REQ-033 CNT_WRAP, up, en=1 for 12 cycles from reset -> q 0..9,0,1; tc high only with q=0 after 9; ovf=1.
REQ-034 CNT_WRAP, down from load_val=0 -> q 9,8,...; tc with q=9; load_val=13 -> q=9 (clamp).
REQ-035 CNT_SAT, up from load 8 -> q 9,9,9; tc high on each step held at 9; down then -> 8.
REQ-036 PRESCALE=3, en toggled 1,1,0,1 -> q steps only after third en-high cycle; clr mid-phase restarts phase.
REQ-037 clr and load same cycle -> q=0; ovf_clr with boundary event same cycle -> ovf stays 1.
REQ-038 reset pulsed low mid-count (q=5) between edges -> q, tc, ovf = 0 immediately; resumes 0,1 after release.
